dragon_pursuit_unit: RTL
========================

Name: dragon_pursuit_unit

Overview:
- Parametrised grid-movement controller for an enemy head sprite. Advances one tile per movement period, counted in vsync frames.
- Supports four modes: hold, chase a target, flee a target, return home. Coordinate width, grid bounds, period, stop distance and start tile are all parameters.
- Sits between the game-state logic (player position, mode select) and the body-segment and sprite renderers, which consume pos and direction.

Parameters:
- COORD_W, 4, bits per axis coordinate.
- X_MAX, 15, largest legal x coordinate.
- Y_MAX, 15, largest legal y coordinate.
- PERIOD, 10, vsync rising edges per movement step (>=1).
- CNT_W, 6, frame counter width; PERIOD <= 2^CNT_W.
- STOP_DIST, 1, chase halts when Chebyshev distance <= STOP_DIST.
- START_X, 0, x coordinate after reset.
- START_Y, 0, y coordinate after reset.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- vsync  in  1  frame sync; a rising edge is one frame
- mode  in  2  00 HOLD, 01 CHASE, 10 FLEE, 11 HOME
- target_pos  in  2*COORD_W  {x,y} of the chase/flee target
- home_pos  in  2*COORD_W  {x,y} home tile for HOME mode
- pos  out  2*COORD_W  {x,y} current tile, registered
- direction  out  2  last move: 00 up, 01 right, 10 down, 11 left
- moved  out  1  one-cycle pulse on each cycle pos changes
- at_goal  out  1  level, registered: goal condition of the current mode met
- frame_count  out  CNT_W  frames elapsed in the current period

Behaviour:
- Reset (reset==0 at a clk edge):
  - pos={START_X,START_Y}, direction=00, moved=0, at_goal=0, frame_count=0, vsync_q=0.
  - Reset mid-period discards the partial count.
- Frame tick: vsync_q registers vsync every cycle; tick = vsync & ~vsync_q. vsync held high gives exactly one tick.
- Frame counting on tick:
  - frame_count < PERIOD-1: increment.
  - Otherwise: frame_count<=0 and a step is evaluated in the same cycle. pos, direction and moved update at that clock edge.
  - Latency from the tick cycle to the new pos is one edge.
  - The counter runs in every mode, including HOLD. A mode change never resets it.
- Step evaluation:
  - Inputs: registered pos and the mode/target_pos/home_pos sampled in the tick cycle.
  - Distances: adx=|tx-px|, ady=|ty-py|, unsigned, COORD_W bits.
  - HOLD: no move.
  - CHASE: if max(adx,ady) <= STOP_DIST, no move. Else if adx>=ady, step x by ±1 toward target; else step y toward target.
  - FLEE:
    - Primary axis is x if adx>=ady, else y. Step 1 away from the target on the primary axis.
    - If that would leave [0,X_MAX]/[0,Y_MAX], or the target coordinate equals pos on that axis, try the other axis the same way.
    - If both are blocked, no move.
  - HOME: as CHASE toward home_pos with stop distance 0.
- Bounds: pos never leaves [0..X_MAX]×[0..Y_MAX]. Out-of-range target or home values are still obeyed, but no step crosses a bound.
- direction updates only when a move occurs and holds otherwise.
- moved: 1 for exactly the cycle after the step edge; 0 when the step yields no move.
- at_goal: updated every cycle from registered pos.
  - CHASE: 1 when max(adx,ady) <= STOP_DIST.
  - HOME: 1 when pos == home_pos.
  - HOLD and FLEE: 0.
- No internal state other than vsync_q, frame_count and the outputs.

Test Plan:
1. Reset held low 3 cycles, then released with no vsync activity -> pos=0x00, direction=00, moved=0, at_goal=0, frame_count=0.
2. CHASE, target (5,2), 50 vsync edges -> pos steps (1,0),(2,0),(3,0),(4,0) with dir 01, then (4,1) with dir 10. Further edges give no move, moved stays 0 and at_goal=1.
3. From (4,1), FLEE, target (5,2), 10 edges -> adx=ady=1, pos=(3,1), direction=11, one moved pulse.
4. FLEE from (0,0), target (3,8), 10 edges -> y and x are both blocked at 0, so pos stays (0,0) and moved=0.
5. From (4,1), HOME, home (2,1), 20 edges -> pos=(3,1) then (2,1), direction=11, at_goal=1. Further edges give no move.
6. vsync held high 100 cycles counts one frame only. Mid-period at frame_count=9, assert reset -> frame_count=0, pos=(0,0); the next step occurs 10 edges after release.

Source files
------------

// File: rtl/dragon_pursuit_unit.sv
// rtl/dragon_pursuit_unit.sv - grid-movement controller for an enemy head sprite
//
// Advances the head one tile every PERIOD vsync frames, according to the mode:
// hold, chase target_pos, flee target_pos, or return to home_pos.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-low reset
//   vsync        frame sync; each rising edge counts one frame
//   mode         00 HOLD, 01 CHASE, 10 FLEE, 11 HOME
//   target_pos   {x,y} chase/flee target
//   home_pos     {x,y} home tile used in HOME mode
//   pos          {x,y} current tile (registered)
//   direction    last move: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1)
//   moved        one-cycle pulse in the cycle after pos changes
//   at_goal      goal condition of the current mode (registered)
//   frame_count  frames elapsed in the current movement period
module dragon_pursuit_unit #(
  parameter int COORD_W   = 4,
  parameter int X_MAX     = 15,
  parameter int Y_MAX     = 15,
  parameter int PERIOD    = 10,
  parameter int CNT_W     = 6,
  parameter int STOP_DIST = 1,
  parameter int START_X   = 0,
  parameter int START_Y   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vsync,
  input  logic [1:0]             mode,
  input  logic [2*COORD_W-1:0]   target_pos,
  input  logic [2*COORD_W-1:0]   home_pos,
  output logic [2*COORD_W-1:0]   pos,
  output logic [1:0]             direction,
  output logic                   moved,
  output logic                   at_goal,
  output logic [CNT_W-1:0]       frame_count
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_CHASE = 2'b01;
  localparam logic [1:0] MODE_FLEE  = 2'b10;
  localparam logic [1:0] MODE_HOME  = 2'b11;

  localparam logic [COORD_W-1:0] X_LIM  = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] Y_LIM  = COORD_W'(Y_MAX);
  localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  logic               vsync_q;
  logic               tick;
  logic [COORD_W-1:0] px, py, tx, ty, hx, hy;
  logic [COORD_W-1:0] adx, ady, hdx, hdy;
  logic               chase_far, home_far;
  logic               x_away_ok, y_away_ok;
  logic               mv_x, mv_y, mv_neg;
  logic               goal_next;
  logic [COORD_W-1:0] nx, ny;
  logic [1:0]         dir_next;

  assign tick = vsync & ~vsync_q;

  assign px = pos[2*COORD_W-1:COORD_W];
  assign py = pos[COORD_W-1:0];
  assign tx = target_pos[2*COORD_W-1:COORD_W];
  assign ty = target_pos[COORD_W-1:0];
  assign hx = home_pos[2*COORD_W-1:COORD_W];
  assign hy = home_pos[COORD_W-1:0];

  assign adx = (tx >= px) ? tx - px : px - tx;
  assign ady = (ty >= py) ? ty - py : py - ty;
  assign hdx = (hx >= px) ? hx - px : px - hx;
  assign hdy = (hy >= py) ? hy - py : py - hy;

  // Chebyshev distance above the stop distance on either axis means "keep going".
  assign chase_far = (int'(adx) > STOP_DIST) || (int'(ady) > STOP_DIST);
  assign home_far  = (hdx != '0) || (hdy != '0);

  // Fleeing along an axis is possible only if the target is offset on that
  // axis and the step away stays inside the grid.
  assign x_away_ok = (tx != px) && ((tx > px) ? (px != '0) : (px < X_LIM));
  assign y_away_ok = (ty != py) && ((ty > py) ? (py != '0) : (py < Y_LIM));

  // Move selection: one axis and a sign (mv_neg = step towards 0).
  always_comb begin
    mv_x   = 1'b0;
    mv_y   = 1'b0;
    mv_neg = 1'b0;
    case (mode)
      MODE_CHASE: begin
        if (chase_far) begin
          if (adx >= ady) begin
            mv_neg = (tx < px);
            mv_x   = mv_neg ? (px != '0) : (px < X_LIM);
          end else begin
            mv_neg = (ty < py);
            mv_y   = mv_neg ? (py != '0) : (py < Y_LIM);
          end
        end
      end
      MODE_HOME: begin
        if (home_far) begin
          if (hdx >= hdy) begin
            mv_neg = (hx < px);
            mv_x   = mv_neg ? (px != '0) : (px < X_LIM);
          end else begin
            mv_neg = (hy < py);
            mv_y   = mv_neg ? (py != '0) : (py < Y_LIM);
          end
        end
      end
      MODE_FLEE: begin
        if (adx >= ady) begin
          if (x_away_ok) begin
            mv_x   = 1'b1;
            mv_neg = (tx > px);
          end else if (y_away_ok) begin
            mv_y   = 1'b1;
            mv_neg = (ty > py);
          end
        end else begin
          if (y_away_ok) begin
            mv_y   = 1'b1;
            mv_neg = (ty > py);
          end else if (x_away_ok) begin
            mv_x   = 1'b1;
            mv_neg = (tx > px);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    nx       = px;
    ny       = py;
    dir_next = direction;
    if (mv_x) begin
      nx       = mv_neg ? px - ONE : px + ONE;
      dir_next = mv_neg ? 2'b11 : 2'b01;
    end else if (mv_y) begin
      ny       = mv_neg ? py - ONE : py + ONE;
      dir_next = mv_neg ? 2'b00 : 2'b10;
    end
  end

  always_comb begin
    goal_next = 1'b0;
    case (mode)
      MODE_CHASE: goal_next = ~chase_far;
      MODE_HOME:  goal_next = (pos == home_pos);
      default:    goal_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pos         <= {COORD_W'(START_X), COORD_W'(START_Y)};
      direction   <= 2'b00;
      moved       <= 1'b0;
      at_goal     <= 1'b0;
      frame_count <= '0;
      vsync_q     <= 1'b0;
    end else begin
      vsync_q <= vsync;
      at_goal <= goal_next;
      moved   <= 1'b0;
      if (tick) begin
        if (frame_count < CNT_LAST) begin
          frame_count <= frame_count + CNT_ONE;
        end else begin
          frame_count <= '0;
          if (mv_x || mv_y) begin
            pos       <= {nx, ny};
            direction <= dir_next;
            moved     <= 1'b1;
          end
        end
      end
    end
  end

endmodule
